// File: rtl/frog_tick_ctrl.sv
// frog_tick_ctrl: game-speed scheduler for the frog game.
// A run/pause/stop FSM paces a period counter whose length depends on the game level.
// Each completed period emits a one-cycle tick and toggles a square wave.
// Every output is registered in the clk domain; nothing runs on a derived clock.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst       asynchronous active-low reset
//   start     IDLE->RUN (fresh start) or PAUSE->RUN (resume)
//   pause     RUN->PAUSE
//   stop      any state->IDLE (highest priority)
//   level_ld  load level_in into the level register
//   level_in  requested level 0..3
//   tick      one-cycle pulse per period, RUN only
//   sq_out    toggles with every tick
//   state     00 IDLE, 01 RUN, 10 PAUSE
//   level     current level
//   tick_cnt  ticks since the last start from IDLE, wraps 255->0
//
// Optional feature macro: LEVEL_AUTO_EN. When defined, the level steps up by one
// (saturating at 3) each time tick_cnt reaches a multiple of LEVEL_TICKS.
module frog_tick_ctrl #(
  parameter int unsigned CNT_W       = 25,
  parameter int unsigned BASE_PERIOD = 250,
  parameter int unsigned STEP_DEC    = 50,
  parameter int unsigned MIN_PERIOD  = 50,
  parameter int unsigned LEVEL_TICKS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic       level_ld,
  input  logic [1:0] level_in,
  output logic       tick,
  output logic       sq_out,
  output logic [1:0] state,
  output logic [1:0] level,
  output logic [7:0] tick_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t           st_q, st_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [CNT_W-1:0] period_q, period_nxt;
  logic [1:0]       level_nxt;
  logic [7:0]       tick_cnt_nxt;
  logic             tick_nxt;
  logic             sq_nxt;
  logic             wrap;

  // Period for a level, clamped to MIN_PERIOD on underflow or when too short.
  function automatic logic [CNT_W-1:0] period_of(input logic [1:0] lvl);
    logic [CNT_W:0] dec;
    logic [CNT_W:0] base;
    dec  = (CNT_W+1)'(lvl) * (CNT_W+1)'(STEP_DEC);
    base = (CNT_W+1)'(BASE_PERIOD);
    if ((dec > base) || ((base - dec) < (CNT_W+1)'(MIN_PERIOD)))
      period_of = CNT_W'(MIN_PERIOD);
    else
      period_of = CNT_W'(base - dec);
  endfunction

  assign wrap  = (st_q == RUN) && (cnt_q == (period_q - CNT_W'(1)));
  assign state = st_q;

`ifndef LEVEL_AUTO_EN
  logic unused_level_ticks;
  assign unused_level_ticks = ^LEVEL_TICKS;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q     <= IDLE;
      cnt_q    <= '0;
      period_q <= CNT_W'(BASE_PERIOD);
      level    <= 2'd0;
      tick     <= 1'b0;
      sq_out   <= 1'b0;
      tick_cnt <= 8'd0;
    end else begin
      st_q     <= st_nxt;
      cnt_q    <= cnt_nxt;
      period_q <= period_nxt;
      level    <= level_nxt;
      tick     <= tick_nxt;
      sq_out   <= sq_nxt;
      tick_cnt <= tick_cnt_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    st_nxt       = st_q;
    cnt_nxt      = cnt_q;
    period_nxt   = period_q;
    level_nxt    = level_ld ? level_in : level;
    tick_nxt     = 1'b0;
    sq_nxt       = sq_out;
    tick_cnt_nxt = tick_cnt;

    unique case (st_q)
      IDLE: begin
        if (!stop && start) begin
          st_nxt       = RUN;
          cnt_nxt      = '0;
          tick_cnt_nxt = 8'd0;
          period_nxt   = period_of(level_nxt);
        end
      end
      RUN: begin
        if (stop) begin
          // A wrap coinciding with stop is dropped: no tick.
          st_nxt  = IDLE;
          cnt_nxt = '0;
          sq_nxt  = 1'b0;
        end else begin
          if (wrap) begin
            // A completed period always ticks, even when pause arrives with it.
            cnt_nxt      = '0;
            tick_nxt     = 1'b1;
            sq_nxt       = ~sq_out;
            tick_cnt_nxt = tick_cnt + 8'd1;
`ifdef LEVEL_AUTO_EN
            if (!level_ld && ((tick_cnt_nxt % 8'(LEVEL_TICKS)) == 8'd0) && (level != 2'd3))
              level_nxt = level + 2'd1;
`endif
            // Period only changes at a boundary so a running period is never cut short.
            period_nxt   = period_of(level_nxt);
          end else if (!pause) begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
          if (pause) st_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (stop) begin
          st_nxt  = IDLE;
          cnt_nxt = '0;
          sq_nxt  = 1'b0;
        end else if (start) begin
          st_nxt = RUN;
        end
      end
      default: begin
        st_nxt  = IDLE;
        cnt_nxt = '0;
        sq_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_frog_tick_ctrl.sv
// Directed and randomized bench for frog_tick_ctrl with an integer-arithmetic reference model.
module tb_frog_tick_ctrl;

  localparam int BASE = 250;
  localparam int STEP = 50;
  localparam int MINP = 50;
  localparam int LTICKS = 16;

  logic       clk;
  logic       rst;
  logic       start, pause, stop, level_ld;
  logic [1:0] level_in;
  logic       tick, sq_out;
  logic [1:0] state, level;
  logic [7:0] tick_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 run, 2 pause; pos = cycles into current period.
  int m_mode, m_pos, m_per, m_lvl, m_tc;
  bit m_tick, m_sq;

  frog_tick_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
    .level_ld(level_ld), .level_in(level_in), .tick(tick), .sq_out(sq_out),
    .state(state), .level(level), .tick_cnt(tick_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int per_of(input int l);
    int p;
    p = BASE - l * STEP;
    return (p < MINP) ? MINP : p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_per = BASE; m_lvl = 0; m_tc = 0; m_tick = 0; m_sq = 0;
  endtask

  task automatic model_update(input bit s, input bit p, input bit sp, input bit ld, input int li);
    int nl;
    nl = ld ? li : m_lvl;
    m_tick = 0;
    case (m_mode)
      0: if (!sp && s) begin m_mode = 1; m_pos = 0; m_tc = 0; m_per = per_of(nl); end
      1: begin
        if (sp) begin
          m_mode = 0; m_pos = 0; m_sq = 0;
        end else begin
          if (m_pos == m_per - 1) begin
            m_pos = 0; m_tick = 1; m_sq = ~m_sq; m_tc = (m_tc + 1) % 256;
`ifdef LEVEL_AUTO_EN
            if (!ld && (m_tc % LTICKS) == 0 && m_lvl < 3) nl = m_lvl + 1;
`endif
            m_per = per_of(nl);
          end else if (!p) begin
            m_pos++;
          end
          if (p) m_mode = 2;
        end
      end
      default: begin
        if (sp) begin m_mode = 0; m_pos = 0; m_sq = 0; end
        else if (s) m_mode = 1;
      end
    endcase
    m_lvl = nl;
  endtask

  task automatic compare_all();
    chk("tick", 32'(tick), 32'(m_tick));
    chk("sq_out", 32'(sq_out), 32'(m_sq));
    chk("state", 32'(state), 32'(m_mode));
    chk("level", 32'(level), 32'(m_lvl));
    chk("tick_cnt", 32'(tick_cnt), 32'(m_tc));
  endtask

  // One clock: drive inputs, advance model on the edge, compare 1 time unit later.
  task automatic step(input bit s, input bit p, input bit sp, input bit ld, input logic [1:0] li);
    start = s; pause = p; stop = sp; level_ld = ld; level_in = li;
    @(posedge clk);
    if (!rst) model_reset();
    else model_update(s, p, sp, ld, int'(li));
    #1;
    compare_all();
    start = 0; pause = 0; stop = 0; level_ld = 0; level_in = 2'd0;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 2'd0);
  endtask

  // Steps until tick is seen; returns the number of steps taken (bounded).
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step(0, 0, 0, 0, 2'd0);
      n++;
    end while (tick !== 1'b1 && n < 2000);
  endtask

  int n;
  bit saw_tick;

  initial begin
    rst = 1'b0; start = 0; pause = 0; stop = 0; level_ld = 0; level_in = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_sq", 32'(sq_out), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_tick_cnt", 32'(tick_cnt), 32'd0);
    rst = 1'b1;
    idle_steps(2);

    // Level 0 run: ticks every 250 cycles, sq_out follows.
    step(1, 0, 0, 0, 2'd0);
    wait_tick(n); chk("first_tick_250", 32'(n), 32'd250);
    chk("sq_after_t1", 32'(sq_out), 32'd1);
    wait_tick(n); chk("second_tick_250", 32'(n), 32'd250);
    chk("sq_after_t2", 32'(sq_out), 32'd0);
    wait_tick(n); chk("third_tick_250", 32'(n), 32'd250);

    // level_ld=3 mid-period: current period completes, next is 100.
    idle_steps(99);
    step(0, 0, 0, 1, 2'd3);
    chk("level_imm", 32'(level), 32'd3);
    wait_tick(n); chk("lvl_change_rest", 32'(n), 32'd150);
    wait_tick(n); chk("lvl3_period", 32'(n), 32'd100);

    // Back to level 0, then pause at counter 120 for 40 cycles.
    step(0, 0, 0, 1, 2'd0);
    wait_tick(n); chk("lvl0_reload_rest", 32'(n), 32'd99);
    idle_steps(120);
    step(0, 1, 0, 0, 2'd0);
    saw_tick = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, 0, 2'd0);
      if (tick !== 1'b0 || state !== 2'b10) saw_tick = 1;
    end
    chk("pause_hold", 32'(saw_tick), 32'd0);
    step(1, 0, 0, 0, 2'd0);
    wait_tick(n); chk("resume_130", 32'(n), 32'd130);

    // pause on the wrap cycle still ticks.
    idle_steps(249);
    step(0, 1, 0, 0, 2'd0);
    chk("pause_wrap_tick", 32'(tick), 32'd1);
    chk("pause_wrap_state", 32'(state), 32'd2);
    step(1, 0, 0, 0, 2'd0);
    // stop on the wrap cycle drops the tick.
    idle_steps(249);
    step(0, 0, 1, 0, 2'd0);
    chk("stop_wrap_tick", 32'(tick), 32'd0);
    chk("stop_wrap_state", 32'(state), 32'd0);

    // stop+pause+start together in RUN.
    step(1, 0, 0, 0, 2'd0);
    idle_steps(10);
    step(1, 1, 1, 0, 2'd0);
    chk("spst_state", 32'(state), 32'd0);
    chk("spst_sq", 32'(sq_out), 32'd0);
    saw_tick = 0;
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 0, 0, 2'd0);
      if (tick !== 1'b0) saw_tick = 1;
    end
    chk("spst_no_tick", 32'(saw_tick), 32'd0);

    // Async reset one cycle before a wrap.
    step(1, 0, 0, 0, 2'd0);
    wait_tick(n); chk("pre_rst_tick", 32'(n), 32'd250);
    step(0, 0, 0, 1, 2'd2);
    idle_steps(248);
    rst = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_sq", 32'(sq_out), 32'd0);
    chk("arst_tick_cnt", 32'(tick_cnt), 32'd0);
    chk("arst_tick", 32'(tick), 32'd0);
    model_reset();
    @(negedge clk);
    idle_steps(3);
    rst = 1'b1;
    saw_tick = 0;
    for (int i = 0; i < 260; i++) begin
      step(0, 0, 0, 0, 2'd0);
      if (tick !== 1'b0 || state !== 2'b00) saw_tick = 1;
    end
    chk("arst_release_quiet", 32'(saw_tick), 32'd0);

    // Randomized commands checked against the model every cycle.
    for (int i = 0; i < 6000; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 149) == 0, $urandom_range(0, 39) == 0,
           2'($urandom_range(0, 3)));
    end

`ifdef LEVEL_AUTO_EN
    // Auto level-up every 16 ticks, saturating at 3.
    step(0, 0, 1, 1, 2'd0);
    step(1, 0, 0, 0, 2'd0);
    for (int t = 1; t <= 64; t++) begin
      wait_tick(n);
      if (t > 48) chk("auto_lvl3_period", 32'(n), 32'd100);
      if (t % 16 == 0) chk("auto_level", 32'(level), 32'((t / 16 > 3) ? 3 : t / 16));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
